// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar source port.
//   N       number of crossbar outputs (width of req_out / gnt_in)
//   DW      flit payload width
//   DEST_W  width of a destination index
//   DEPTH   flit FIFO depth (power of two, >= 2)
//   TO_CYC  request timeout in cycles (only used with XBAR_REQ_TIMEOUT_EN)
// Also holds the requester FSM encoding and the buffered flit layout.
package xbar_pkg;
  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int DEST_W = (N > 1) ? $clog2(N) : 1;
  localparam int DEPTH  = 4;
  localparam int TO_CYC = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  typedef struct packed {
    logic              last;
    logic [DEST_W-1:0] dest;
    logic [DW-1:0]     data;
  } flit_t;

  // Destination indices beyond the last output cannot be requested.
  function automatic logic dest_ok(input logic [DEST_W-1:0] d);
    return int'(d) < N;
  endfunction

  function automatic logic [N-1:0] dest_onehot(input logic [DEST_W-1:0] d);
    return {{(N-1){1'b0}}, 1'b1} << d;
  endfunction
endpackage

// File: rtl/xbar_flit_fifo.sv
// Synchronous flit FIFO for the crossbar source port.
//   clk, rst_i  clock and asynchronous active-high reset (empties the FIFO)
//   push_i      write wr_i when not full (a push while full is dropped)
//   wr_i        flit to write
//   pop_i       remove head flit when not empty
//   rd_o        current head flit (valid while !empty_o)
//   full_o      DEPTH flits stored
//   empty_o     no flit stored
module xbar_flit_fifo
  import xbar_pkg::*;
(
  input  logic  clk,
  input  logic  rst_i,
  input  logic  push_i,
  input  flit_t wr_i,
  input  logic  pop_i,
  output flit_t rd_o,
  output logic  full_o,
  output logic  empty_o
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  flit_t            mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNTW'(DEPTH));
  assign empty_o = (count_q == '0);
  // Full is checked on the stored count only, so a push while full is
  // dropped even if a pop happens in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rd_o    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CNTW'(do_push) - CNTW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_i;
  end
endmodule

// File: rtl/xbar_src_port.sv
// Crossbar source port: buffers ingress flits, requests the destination
// output's arbiter with a one-hot req_out, streams the packet while the
// matching grant bit is high, then drops the request for at least a cycle.
//   clk, rst_in        clock, asynchronous active-high reset
//   in_valid/in_ready  ingress handshake (in_ready = FIFO not full)
//   in_data/in_dest/in_last  ingress flit (dest taken from head flit only)
//   req_out / gnt_in   one-hot request to / grant from the output arbiters
//   tx_valid/tx_data/tx_last  flit toward the crossbar mux (registered)
//   timeout            one-cycle pulse when a request is abandoned
// Optional feature: define XBAR_REQ_TIMEOUT_EN to abandon a request after
// TO_CYC cycles without grant and re-request; otherwise timeout is tied 0.
module xbar_src_port
  import xbar_pkg::*;
(
  input  logic              clk,
  input  logic              rst_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_last,
  output logic [N-1:0]      req_out,
  input  logic [N-1:0]      gnt_in,
  output logic              tx_valid,
  output logic [DW-1:0]     tx_data,
  output logic              tx_last,
  output logic              timeout
);
  flit_t             wr_flit, head;
  logic              full, empty, push, pop;
  state_e            state_q, state_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic              drop_q, drop_d;
  logic [N-1:0]      req_q, req_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DW-1:0]     tx_data_q, tx_data_d;
  logic              tx_last_q, tx_last_d;

  assign wr_flit  = '{last: in_last, dest: in_dest, data: in_data};
  assign in_ready = ~full;
  assign push     = in_valid & ~full;

  xbar_flit_fifo u_fifo (
    .clk     (clk),
    .rst_i   (rst_in),
    .push_i  (push),
    .wr_i    (wr_flit),
    .pop_i   (pop),
    .rd_o    (head),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef XBAR_REQ_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    drop_d     = drop_q;
    req_d      = req_q;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    tx_last_d  = tx_last_q;
    pop        = 1'b0;
`ifdef XBAR_REQ_TIMEOUT_EN
    cnt_d      = '0;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          dest_d = head.dest;
          if (dest_ok(head.dest)) begin
            req_d   = dest_onehot(head.dest);
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            // Unroutable packet: never request, just drain it silently.
            drop_d  = 1'b1;
            state_d = ST_XFER;
          end
        end
      end
      ST_REQ, ST_XFER: begin
        if (drop_q) begin
          if (!empty) begin
            pop = 1'b1;
            if (head.last) begin
              drop_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end else if (gnt_in[dest_q] && !empty) begin
          // Popping in the grant cycle gives tx_valid one cycle after grant.
          pop        = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = head.data;
          tx_last_d  = head.last;
          if (head.last) begin
            req_d   = '0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_XFER;
          end
        end
`ifdef XBAR_REQ_TIMEOUT_EN
        else if (state_q == ST_REQ) begin
          if (cnt_q == CW'(TO_CYC - 1)) begin
            // Abandon; IDLE re-requests the same head flit next cycle.
            req_d     = '0;
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      dest_q     <= '0;
      drop_q     <= 1'b0;
      req_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      drop_q     <= drop_d;
      req_q      <= req_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_last_q  <= tx_last_d;
    end
  end

  assign req_out  = req_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign tx_last  = tx_last_q;
endmodule

// File: tb/tb_xbar_src_port.sv
module tb_xbar_src_port;
  import xbar_pkg::*;

  logic              clk = 1'b0;
  logic              rst_in;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic [DEST_W-1:0] in_dest;
  logic              in_last;
  logic [N-1:0]      req_out;
  logic [N-1:0]      gnt_in;
  logic              tx_valid;
  logic [DW-1:0]     tx_data;
  logic              tx_last;
  logic              timeout;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW:0] exp_q[$];

  always #5 clk = ~clk;

  xbar_src_port dut (
    .clk      (clk),
    .rst_in   (rst_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .in_last  (in_last),
    .req_out  (req_out),
    .gnt_in   (gnt_in),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .timeout  (timeout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic push(input logic [7:0] d, input logic [1:0] dst, input logic l,
                      input logic exp_acc);
    in_valid = 1'b1;
    in_data  = d;
    in_dest  = dst;
    in_last  = l;
    if (exp_acc) exp_q.push_back({l, d});
    @(negedge clk);
    chk("push_accept", in_ready, exp_acc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_req(input string nm, input logic [N-1:0] exp);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_out != '0) break;
    end
    chk(nm, req_out, exp);
  endtask

  task automatic wait_idle(input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if (req_out == '0 && !tx_valid && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, ok, 1'b1);
    gnt_in = '0;
  endtask

  initial begin
    int seen;
    logic gap;
    logic to_seen;
    logic [DW:0] e;
    rst_in = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = '0; in_last = 1'b0; gnt_in = '0;

    fork
      begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
      end
      forever begin
        @(negedge clk);
        if (!rst_in && tx_valid) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL tx_unexpected: got %0h expected none", {tx_last, tx_data});
          end else begin
            e = exp_q.pop_front();
            if ({tx_last, tx_data} !== e) begin
              n_fail++;
              $display("FAIL tx_flit: got %0h expected %0h", {tx_last, tx_data}, e);
            end
          end
        end
      end
    join_none

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_req", req_out, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_rdy", in_ready, 1);
    chk("rst_data", tx_data, 0);
    chk("rst_last", tx_last, 0);
    chk("rst_to", timeout, 0);
    rst_in = 1'b0;

    // 3-flit packet to output 2, grant two cycles after request
    sync();
    push(8'hA1, 2'd2, 1'b0, 1'b1);
    push(8'hA2, 2'd2, 1'b0, 1'b1);
    push(8'hA3, 2'd2, 1'b1, 1'b1);
    wait_req("t2_req", 4'b0100);
    @(negedge clk); @(negedge clk);
    chk("t2_no_tx_before_gnt", tx_valid, 0);
    gnt_in = 4'b0100;
    @(negedge clk); chk("t2_tx1", tx_valid, 1);
    @(negedge clk); chk("t2_tx2", tx_valid, 1);
    @(negedge clk); chk("t2_tx3", tx_valid, 1); chk("t2_last", tx_last, 1);
    @(negedge clk); chk("t2_req_drop", req_out, 0);
    wait_idle("t2_idle");

    // Wrong grant bit ignored, right one starts transfer next cycle
    sync();
    push(8'hB1, 2'd1, 1'b0, 1'b1);
    push(8'hB2, 2'd1, 1'b1, 1'b1);
    wait_req("t3_req", 4'b0010);
    gnt_in = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_no_tx", tx_valid, 0);
      chk("t3_req_hold", req_out, 4'b0010);
    end
    gnt_in = 4'b0010;
    @(negedge clk); chk("t3_start", tx_valid, 1);
    wait_idle("t3_idle");

    // Fill FIFO, overflow push dropped, drain with pointer wrap
    sync();
    push(8'hC0, 2'd3, 1'b0, 1'b1);
    push(8'hC1, 2'd3, 1'b0, 1'b1);
    push(8'hC2, 2'd3, 1'b0, 1'b1);
    push(8'hC3, 2'd3, 1'b1, 1'b1);
    @(negedge clk); chk("t4_full_rdy", in_ready, 0);
    sync();
    push(8'hEE, 2'd3, 1'b1, 1'b0);
    wait_req("t4_req", 4'b1000);
    gnt_in = 4'b1000;
    @(negedge clk);
    chk("t4_tx1", tx_valid, 1);
    chk("t4_rdy_after_pop", in_ready, 1);
    wait_idle("t4_idle");

    // Grant withdrawn mid-packet for 3 cycles
    sync();
    push(8'hD0, 2'd0, 1'b0, 1'b1);
    push(8'hD1, 2'd0, 1'b0, 1'b1);
    push(8'hD2, 2'd0, 1'b0, 1'b1);
    push(8'hD3, 2'd0, 1'b1, 1'b1);
    wait_req("t5_req", 4'b0001);
    gnt_in = 4'b0001;
    @(negedge clk); chk("t5_tx1", tx_valid, 1);
    gnt_in = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_stall", tx_valid, 0);
      chk("t5_req_hold", req_out, 4'b0001);
    end
    gnt_in = 4'b0001;
    @(negedge clk); chk("t5_resume", tx_valid, 1);
    wait_idle("t5_idle");

    // Two single-flit packets with grant held: request must drop between them
    gnt_in = 4'b0100;
    sync();
    push(8'hF0, 2'd2, 1'b1, 1'b1);
    push(8'hF1, 2'd2, 1'b1, 1'b1);
    seen = 0;
    gap  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tx_valid) seen++;
      if (seen == 1 && req_out == '0) gap = 1'b1;
    end
    chk("t7_count", seen, 2);
    chk("t7_gap", gap, 1);
    wait_idle("t7_idle");

    // Request timeout
    sync();
    push(8'h5A, 2'd3, 1'b1, 1'b1);
    wait_req("t6_req", 4'b1000);
`ifdef XBAR_REQ_TIMEOUT_EN
    for (int i = 1; i < TO_CYC; i++) begin
      @(negedge clk);
      chk("t6_wait_req", req_out, 4'b1000);
      chk("t6_wait_to", timeout, 0);
    end
    @(negedge clk);
    chk("t6_pulse", timeout, 1);
    chk("t6_req_low", req_out, 0);
    @(negedge clk);
    chk("t6_pulse_end", timeout, 0);
    chk("t6_rereq", req_out, 4'b1000);
`else
    to_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (timeout) to_seen = 1'b1;
    end
    chk("t6_no_timeout", to_seen, 0);
    chk("t6_req_hold", req_out, 4'b1000);
`endif
    gnt_in = 4'b1000;
    wait_idle("t6_idle");

    // Asynchronous reset in the middle of a transfer
    sync();
    push(8'h71, 2'd1, 1'b0, 1'b1);
    push(8'h72, 2'd1, 1'b0, 1'b1);
    push(8'h73, 2'd1, 1'b1, 1'b1);
    wait_req("t1_req", 4'b0010);
    gnt_in = 4'b0010;
    @(negedge clk);
    chk("t1_tx_before_rst", tx_valid, 1);
    #2;
    rst_in = 1'b1;
    #1;
    chk("t1_rst_req", req_out, 0);
    chk("t1_rst_txv", tx_valid, 0);
    chk("t1_rst_rdy", in_ready, 1);
    chk("t1_rst_data", tx_data, 0);
    exp_q.delete();
    gnt_in = '0;
    @(negedge clk);
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("t1_fifo_empty_req", req_out, 0);
    chk("t1_fifo_empty_txv", tx_valid, 0);
    chk("t1_rdy", in_ready, 1);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
